// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//
// Shared definitions for the pipelined carry-lookahead adder:
//   - default operand width and per-stage slice width
//   - cla_stages(): number of pipeline stages for a WIDTH/BLOCK pair
//   - cla_ctl_t:    per-stage control word carried down the pipeline
//
// A stage register holds one cla_ctl_t plus the partial sum and the operand
// words. The operand words still hold their upper, not-yet-resolved bits.
// The control word holds the valid bit, the carry into the next slice, and
// the propagate/generate accumulated over the slices resolved so far.
// -----------------------------------------------------------------------------
package cla_pkg;

   localparam int CLA_DEF_WIDTH = 32;
   localparam int CLA_DEF_BLOCK = 8;

   typedef struct packed {
      logic valid;   // beat present in this stage (0 = bubble)
      logic carry;   // carry into the next unresolved slice
      logic pacc;    // AND of the slice propagates resolved so far
      logic gacc;    // group generate of the bits resolved so far, Cin excluded
   } cla_ctl_t;

   // One pipeline stage per BLOCK-bit slice. A bad configuration returns 0,
   // and the top level also rejects it at elaboration.
   function automatic int cla_stages(input int width, input int block);
      if ((block < 1) || (width < block) || ((width % block) != 0)) begin
         return 0;
      end
      return width / block;
   endfunction

endpackage

// File: rtl/cla_block.sv
// -----------------------------------------------------------------------------
// cla_block
//
// Purely combinational BLOCK-bit carry-lookahead slice.
// Each carry comes from the prefix group generate/propagate, so no carry
// ripples through the bits.
//
// Ports:
//   a, b  in  BLOCK  slice operands (b is already inverted for subtraction)
//   ci    in  1      carry into bit 0 of the slice
//   s     out BLOCK  slice sum
//   co    out 1      carry out of the slice MSB
//   p     out 1      slice group propagate (AND of a^b)
//   g     out 1      slice group generate (ci excluded)
// -----------------------------------------------------------------------------
module cla_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             p,
   output logic             g
);

   logic [BLOCK-1:0] bit_p;   // per-bit propagate
   logic [BLOCK-1:0] bit_g;   // per-bit generate
   logic [BLOCK-1:0] pre_p;   // group propagate over bits [i:0]
   logic [BLOCK-1:0] pre_g;   // group generate over bits [i:0]
   logic [BLOCK:0]   carry;   // carry into bit i; carry[BLOCK] is the slice carry out

   assign bit_p = a ^ b;
   assign bit_g = a & b;

   always_comb begin
      // NOTE: every variable written here gets a value before any branch or
      // loop can skip it, so this block never infers a latch.
      pre_p = '0;
      pre_g = '0;
      carry = '0;

      // NOTE: blocking assignments are deliberate here. Each prefix term
      // reads the term written one iteration earlier in the same pass.
      pre_p[0] = bit_p[0];
      pre_g[0] = bit_g[0];
      for (int i = 1; i < BLOCK; i++) begin
         pre_p[i] = bit_p[i] & pre_p[i-1];
         pre_g[i] = bit_g[i] | (bit_p[i] & pre_g[i-1]);
      end

      // Every carry is a two-level function of ci and the prefix terms.
      carry[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         carry[i+1] = pre_g[i] | (pre_p[i] & ci);
      end
   end

   assign s  = bit_p ^ carry[BLOCK-1:0];
   assign co = carry[BLOCK];
   assign p  = pre_p[BLOCK-1];
   assign g  = pre_g[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Streaming, parametrised carry-lookahead adder/subtractor.
// A WIDTH-bit operation is split into STAGES = WIDTH/BLOCK slices.
// Stage k resolves bits [k*BLOCK +: BLOCK] using the carry registered by
// stage k-1. Latency is STAGES cycles and throughput is one beat per cycle.
// The whole pipeline stalls together: advance = ~out_valid | out_ready.
//
// Parameters:
//   WIDTH  operand/sum width (multiple of BLOCK)
//   BLOCK  bits resolved per pipeline stage
//
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset
//   in_valid   in  1      operand beat valid
//   in_ready   out 1      beat accepted this cycle when in_valid is high
//   A, B       in  WIDTH  operands
//   Cin        in  1      carry in (ignored when sub=1)
//   sub        in  1      0: A+B+Cin   1: A-B
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer accepts the result
//   S          out WIDTH  sum / difference
//   Cout       out 1      carry out of MSB (sub: 1 = no borrow)
//   P          out 1      group propagate over WIDTH
//   G          out 1      group generate over WIDTH, Cin excluded
//   ovf        out 1      two's-complement overflow; present only when
//                         PIPELINED_CLA_OVF_EN is defined
//
// Compile-time option: PIPELINED_CLA_OVF_EN adds the ovf port and its
// pipeline register.
// -----------------------------------------------------------------------------
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_DEF_WIDTH,
   parameter int BLOCK = CLA_DEF_BLOCK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             P,
   output logic             G
`ifdef PIPELINED_CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = cla_stages(WIDTH, BLOCK);
   localparam int LAST   = STAGES - 1;

   if ((BLOCK < 1) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_cfg_error
      $error("pipelined_cla_adder: WIDTH (%0d) must be a positive multiple of BLOCK (%0d)",
             WIDTH, BLOCK);
   end

   // Values entering stage k. They come from the ports for k=0 and from
   // stage register k-1 otherwise.
   logic [WIDTH-1:0] stage_a   [STAGES];
   logic [WIDTH-1:0] stage_b   [STAGES];
   logic [WIDTH-1:0] stage_sum [STAGES];
   cla_ctl_t         stage_ctl [STAGES];

   // Next-state of each stage register.
   logic [WIDTH-1:0] sum_d [STAGES];
   cla_ctl_t         ctl_d [STAGES];

   // Stage registers. The operand registers of the last stage are never
   // loaded: nothing downstream needs them.
   logic [WIDTH-1:0] sum_q [STAGES];
   logic [WIDTH-1:0] opa_q [STAGES];
   logic [WIDTH-1:0] opb_q [STAGES];
   cla_ctl_t         ctl_q [STAGES];

`ifdef PIPELINED_CLA_OVF_EN
   logic ovf_q;
`endif

   logic advance;

   // A result that is not yet taken blocks the whole pipeline, input included.
   assign out_valid = ctl_q[LAST].valid;
   assign advance   = ~out_valid | out_ready;
   assign in_ready  = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [BLOCK-1:0] blk_s;
      logic             blk_co;
      logic             blk_p;
      logic             blk_g;

      if (k == 0) begin : g_head
         // Subtraction is A + ~B + 1. Beff and c0 are captured with the beat.
         assign stage_a[k]   = A;
         assign stage_b[k]   = sub ? ~B : B;
         assign stage_sum[k] = '0;
         assign stage_ctl[k] = '{valid: in_valid, carry: sub | Cin, pacc: 1'b1, gacc: 1'b0};
      end else begin : g_body
         assign stage_a[k]   = opa_q[k-1];
         assign stage_b[k]   = opb_q[k-1];
         assign stage_sum[k] = sum_q[k-1];
         assign stage_ctl[k] = ctl_q[k-1];
      end

      cla_block #(
         .BLOCK (BLOCK)
      ) u_block (
         .a  (stage_a[k][k*BLOCK +: BLOCK]),
         .b  (stage_b[k][k*BLOCK +: BLOCK]),
         .ci (stage_ctl[k].carry),
         .s  (blk_s),
         .co (blk_co),
         .p  (blk_p),
         .g  (blk_g)
      );

      // Sum bits at and above this slice are still zero in the incoming
      // partial sum, so OR-ing the slice result in is enough.
      assign sum_d[k] = stage_sum[k] | (WIDTH'(blk_s) << (k*BLOCK));

      // The new slice is more significant than everything accumulated so
      // far, so its generate takes priority over the accumulated one.
      assign ctl_d[k] = '{valid: stage_ctl[k].valid,
                          carry: blk_co,
                          pacc:  stage_ctl[k].pacc & blk_p,
                          gacc:  blk_g | (blk_p & stage_ctl[k].gacc)};

      if (k < LAST) begin : g_mid
         // NOTE: sequential state is written only with non-blocking
         // assignments, so every stage samples the pre-edge value of its
         // neighbour.
         always_ff @(posedge clk) begin
            // NOTE: only the valid bit of an inner stage is reset. The data
            // behind a cleared valid bit is never observed, so resetting it
            // would only add reset fan-out.
            if (reset) begin
               ctl_q[k].valid <= 1'b0;
            end else if (advance) begin
               if (stage_ctl[k].valid) begin
                  ctl_q[k] <= ctl_d[k];
                  sum_q[k] <= sum_d[k];
                  opa_q[k] <= stage_a[k];
                  opb_q[k] <= stage_b[k];
               end else begin
                  ctl_q[k].valid <= 1'b0;
               end
            end
         end
      end else begin : g_out
         // The output stage is fully reset. It keeps S/Cout/P/G when a
         // bubble passes through, so the data load is gated by the valid bit.
         always_ff @(posedge clk) begin
            if (reset) begin
               ctl_q[k] <= '0;
               sum_q[k] <= '0;
            end else if (advance) begin
               if (stage_ctl[k].valid) begin
                  ctl_q[k] <= ctl_d[k];
                  sum_q[k] <= sum_d[k];
               end else begin
                  ctl_q[k].valid <= 1'b0;
               end
            end
         end

`ifdef PIPELINED_CLA_OVF_EN
         // Recover the carry into the MSB from the MSB sum equation.
         logic msb_carry_in;
         assign msb_carry_in = stage_a[k][WIDTH-1] ^ stage_b[k][WIDTH-1] ^ sum_d[k][WIDTH-1];

         always_ff @(posedge clk) begin
            if (reset) begin
               ovf_q <= 1'b0;
            end else if (advance && stage_ctl[k].valid) begin
               ovf_q <= msb_carry_in ^ blk_co;
            end
         end
`endif
      end
   end

   assign S    = sum_q[LAST];
   assign Cout = ctl_q[LAST].carry;
   assign P    = ctl_q[LAST].pacc;
   assign G    = ctl_q[LAST].gacc;

`ifdef PIPELINED_CLA_OVF_EN
   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Directed bench for pipelined_cla_adder with WIDTH=32 and BLOCK=8.
// The driver pushes the hand-computed result of each accepted beat into a
// queue. The monitor pops and compares on every out_valid && out_ready cycle.
// Compile with PIPELINED_CLA_OVF_EN to also compare the ovf flag.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        p;
      logic        g;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        Cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] S;
   logic        Cout;
   logic        P;
   logic        G;
`ifdef PIPELINED_CLA_OVF_EN
   logic        ovf;
`endif

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_out    = 0;

   pipelined_cla_adder #(
      .WIDTH (32),
      .BLOCK (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .P         (P),
      .G         (G)
`ifdef PIPELINED_CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] s, input logic cout, input logic p,
                               input logic g, input logic ov);
      exp_t e;
      e.s    = s;
      e.cout = cout;
      e.p    = p;
      e.g    = g;
      e.ovf  = ov;
      return e;
   endfunction

   // Scoreboard monitor. It samples on the falling edge, so a transfer seen
   // here completes on the next rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("beat%0d.S", n_out), S, mon_e.s);
            check($sformatf("beat%0d.Cout", n_out), 32'(Cout), 32'(mon_e.cout));
            check($sformatf("beat%0d.P", n_out), 32'(P), 32'(mon_e.p));
            check($sformatf("beat%0d.G", n_out), 32'(G), 32'(mon_e.g));
`ifdef PIPELINED_CLA_OVF_EN
            check($sformatf("beat%0d.ovf", n_out), 32'(ovf), 32'(mon_e.ovf));
`endif
            n_out++;
         end
      end
   end

   // Expects to be called at posedge+1. Presents a beat until it is accepted
   // and returns at posedge+1 just after the accepting edge, with in_valid
   // still high so that beats can follow back to back.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic s_sub, input exp_t e);
      bit took = 1'b0;
      A        = a;
      B        = b;
      Cin      = cin;
      sub      = s_sub;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !took; t++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            took = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check("send_accepted", 32'(took), 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drained", 32'(exp_q.size()), 32'd0);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int base;

      reset     = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.S", S, 32'h0);
      check("rst.Cout", 32'(Cout), 32'd0);
      check("rst.P", 32'(P), 32'd0);
      check("rst.G", 32'(G), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Full carry chain with latency measurement; out_valid lasts one cycle.
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check("latency", 32'(lat), 32'd4);
      @(negedge clk);
      check("out_valid_single_cycle", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Directed vectors, back to back.
      send(32'h5, 32'h7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'h7, 32'h5, 1'b0, 1'b1, mk(32'h2, 1'b1, 1'b0, 1'b1, 1'b0));
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
      send(32'h0, 32'h0, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
      send(32'h9, 32'h9, 1'b1, 1'b1, mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
      send(32'hFF, 32'h1, 1'b0, 1'b0, mk(32'h100, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1));
      drain();

      // Eight back-to-back beats must give eight consecutive results.
      fork
         begin
            for (int i = 1; i <= 8; i++) begin
               send(32'(i), 32'(32'h10 * i), 1'b0, 1'b0,
                    mk(32'(32'h11 * i), 1'b0, 1'b0, 1'b0, 1'b0));
            end
            in_valid = 1'b0;
         end
         begin
            int wait_n = 0;
            int run    = 0;
            while (!out_valid && wait_n < 40) begin
               @(negedge clk);
               wait_n++;
            end
            while (out_valid && run < 20) begin
               run++;
               @(negedge clk);
            end
            check("burst_consecutive", 32'(run), 32'd8);
         end
      join
      drain();

      // Stall: fill with out_ready=0, then hold for five cycles.
      base      = n_out;
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send(32'(32'h100 * i), 32'(i), 1'b0, 1'b0,
              mk(32'(32'h101 * i), 1'b0, 1'b0, 1'b0, 1'b0));
      end
      A        = 32'h500;
      B        = 32'h5;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall.in_ready", 32'(in_ready), 32'd0);
         check("stall.out_valid", 32'(out_valid), 32'd1);
         check("stall.S_held", S, 32'h101);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(32'h500, 32'h5, 1'b0, 1'b0, mk(32'h505, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'h600, 32'h6, 1'b0, 1'b0, mk(32'h606, 1'b0, 1'b0, 1'b0, 1'b0));
      drain();
      check("stall.out_count", 32'(n_out - base), 32'd6);

      // Reset with three beats in flight: they must vanish.
      for (int i = 1; i <= 3; i++) begin
         send(32'(32'h1111_0000 + i), 32'h1, 1'b0, 1'b0,
              mk(32'(32'h1111_0001 + i), 1'b0, 1'b0, 1'b0, 1'b0));
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      exp_q.delete();
      base = n_out;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.S", S, 32'h0);
      idle(10);
      check("midrst.no_stale", 32'(n_out - base), 32'd0);

      // The pipeline works normally after the reset.
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
           mk(32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
